// File: rtl/dmem_pkg.sv
// Shared widths and port indices for the data-memory arbiter slice.
package dmem_pkg;
   localparam int DMEM_ADDR_W = 5;
   localparam int DMEM_DATA_W = 32;

   typedef enum logic {
      PORT_PIPE = 1'b0,
      PORT_DBG  = 1'b1
   } portSel_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the two-port data-memory arbiter.
interface dmem_arbiter_if
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
);
   logic              req0, we0, gnt0, rvalid0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              req1, we1, gnt1, rvalid1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic [DATA_W-1:0] rdata;
   logic              memRead, memWrite;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData, memRData;

   // Requesters and the memory model sit on the master side.
   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memRData,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata, memRead, memWrite, memAddr, memWData
   );

   modport slave (
      input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, memRData,
      output gnt0, rvalid0, gnt1, rvalid1, rdata, memRead, memWrite, memAddr, memWData
   );
endinterface

// File: rtl/arb_grant2.sv
// Combinational 2-way grant selector: a lone requester wins, prefer1 breaks ties.
module arb_grant2
   import dmem_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       prefer1,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = 2'b00;
      if (req1 && (!req0 || prefer1)) gnt[PORT_DBG] = 1'b1;
      else if (req0)                  gnt[PORT_PIPE] = 1'b1;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory, one access per cycle.
// DMEM_ARB_RR_EN selects round-robin priority; otherwise fixed priority with a port-1 starvation counter.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MAX_WAIT = 4
)(
   input  logic CLK,
   input  logic RST_N,
   dmem_arbiter_if.slave bus
);
   logic [1:0]        gnt;
   logic              prefer1;
   logic              rvalid0Q, rvalid1Q;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWData;

   arb_grant2 u_grant (
      .req0    (bus.req0),
      .req1    (bus.req1),
      .prefer1 (prefer1),
      .gnt     (gnt)
   );

`ifdef DMEM_ARB_RR_EN
   portSel_t lastGnt, lastGntNext;

   assign prefer1 = (lastGnt == PORT_PIPE);

   always_comb begin
      lastGntNext = lastGnt;
      if (gnt[PORT_PIPE])     lastGntNext = PORT_PIPE;
      else if (gnt[PORT_DBG]) lastGntNext = PORT_DBG;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) lastGnt <= PORT_DBG;
      else        lastGnt <= lastGntNext;
   end
`else
   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
   logic [3:0] waitCnt, waitCntNext;

   assign prefer1 = (waitCnt == WAIT_LIM);

   // Counts consecutive denied cycles of port 1; any grant or idle cycle restarts it.
   always_comb begin
      waitCntNext = 4'd0;
      if (bus.req1 && !gnt[PORT_DBG])
         waitCntNext = (waitCnt == WAIT_LIM) ? waitCnt : waitCnt + 4'd1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) waitCnt <= 4'd0;
      else        waitCnt <= waitCntNext;
   end
`endif

   always_comb begin
      bus.memRead  = 1'b0;
      bus.memWrite = 1'b0;
      selAddr      = '0;
      selWData     = '0;
      if (gnt[PORT_PIPE]) begin
         bus.memRead  = !bus.we0;
         bus.memWrite = bus.we0;
         selAddr      = bus.addr0;
         selWData     = bus.wdata0;
      end else if (gnt[PORT_DBG]) begin
         bus.memRead  = !bus.we1;
         bus.memWrite = bus.we1;
         selAddr      = bus.addr1;
         selWData     = bus.wdata1;
      end
   end

   assign bus.memAddr  = selAddr;
   assign bus.memWData = selWData;
   assign bus.gnt0     = gnt[PORT_PIPE];
   assign bus.gnt1     = gnt[PORT_DBG];

   // Memory read data is registered, so the valid strobe lines up one cycle after the grant.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rvalid0Q <= 1'b0;
         rvalid1Q <= 1'b0;
      end else begin
         rvalid0Q <= gnt[PORT_PIPE] && !bus.we0;
         rvalid1Q <= gnt[PORT_DBG] && !bus.we1;
      end
   end

   assign bus.rvalid0 = rvalid0Q;
   assign bus.rvalid1 = rvalid1Q;
   assign bus.rdata   = bus.memRData;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32x32 data memory between two requesters.
  - Port 0: pipeline MEM stage.
  - Port 1: debug/DMA loader.
- Grants at most one access per cycle and drives the memory's memRead/memWrite/address/writeData.
- Returns read data with a per-port valid strobe.
- Fixed priority to port 0, plus a starvation counter that guarantees port 1 progress.

Parameters:
- ADDR_W, 5, word address width (32 words).
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be denied before it is forced through (range 1..15).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- req0  input  1  port 0 request.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 word address.
- wdata0  input  DATA_W  port 0 write data.
- gnt0  output  1  port 0 access issued at next CLK edge.
- rvalid0  output  1  port 0 read data valid.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  output  DATA_W  read data, shared by both ports, qualified by rvalidX.
- memRead  output  1  to memory.
- memWrite  output  1  to memory.
- memAddr  output  ADDR_W  to memory address.
- memWData  output  DATA_W  to memory writeData.
- memRData  input  DATA_W  from memory readData (registered, 1-cycle latency).

Behaviour:
- Reset (async, RST_N=0): rvalid0=rvalid1=0, waitCnt=0, lastGnt=1. All combinational outputs follow from req=0 (gnt=0, memRead=memWrite=0). memAddr/memWData are don't-care when idle but drive 0. Memory contents are untouched.
- Handshake:
  - Requester holds reqX/weX/addrX/wdataX stable until it sees gntX=1 in the same cycle.
  - gntX is combinational from the current requests and registered state.
  - The access happens at the next CLK edge.
  - The requester may drop or change its request in the cycle after a grant.
  - Back-to-back grants to the same port are allowed.
- Grant (default build):
  - Only one requesting: grant it.
  - Both requesting: grant port 0, unless waitCnt==MAX_WAIT, then grant port 1.
  - Never gnt0 and gnt1 together.
- Memory drive:
  - Granted read: memRead=1, memWrite=0.
  - Granted write: memWrite=1, memRead=0.
  - memAddr/memWData are muxed from the granted port.
  - memRead and memWrite are never both 1.
- waitCnt (4 bits, saturating at MAX_WAIT):
  - Increments when req1=1 and gnt1=0.
  - Clears when gnt1=1 or req1=0.
- Read response:
  - A read granted to port X in cycle N gives rvalidX=1 in cycle N+1, with rdata=memRData.
  - rvalid is a registered pulse: exactly one cycle per granted read.
  - Writes produce no rvalid.
- Latency: read 1 cycle after grant; write completes at the grant edge.
- Read-after-write, same address:
  - Write granted in N, read granted in N+1: the read returns the new data (memory is updated at edge N).
  - Same-cycle conflict is impossible because only one grant is issued per cycle.
- Reset mid-operation: a pending rvalid is dropped and waitCnt cleared. Requesters must reissue.
- No requests: memory idle, no state change except waitCnt clear.

Optional Feature:
- DMEM_ARB_RR_EN defined:
  - Priority is round-robin using the lastGnt register.
  - Both requesting: grant the port opposite lastGnt.
  - lastGnt updates on every grant.
  - waitCnt and MAX_WAIT logic is omitted.
- Undefined: fixed priority with starvation counter, as above. lastGnt is not implemented.

Decomposition:
- Shared package dmem_pkg:
  - DMEM_ADDR_W=5, DMEM_DATA_W=32.
  - Port index constants PORT_PIPE=0, PORT_DBG=1.
- One natural sub-module: arb_grant2, the combinational 2-way grant selector.
  - Inputs: req0, req1, force1 (or lastGnt).
  - Outputs: one-hot grant.
- The top level holds waitCnt, the rvalid registers and the memory muxes.
- The bench instantiates the existing data memory behind the arbiter.

Test Plan:
- Reset then idle, and reset during a pending read:
  - Reset then idle: rvalid0=rvalid1=0, memRead=memWrite=0.
  - Assert RST_N=0 in the cycle after a granted read -> rvalid stays 0.
- Port 0 writes 12 to addr 0, then reads addr 0 -> gnt0 both cycles; rvalid0=1 with rdata=12 one cycle after the read grant; rvalid1=0.
- Port 1 alone writes 0xDEADBEEF to addr 31, then reads it -> gnt1 immediately; rvalid1=1, rdata=0xDEADBEEF.
- Both requesting continuously, MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on the 5th, then waitCnt=0 and the pattern repeats. Never both grants.
- Write addr 5=7 then read addr 5 back-to-back from port 0 -> read returns 7.
- With DMEM_ARB_RR_EN, both ports requesting reads continuously -> grants alternate 0,1,0,1; rvalid0/rvalid1 alternate one cycle later.
